dma_axi4_slave_mem: RTL
=======================

// Module: dma_axi4_slave_mem
// PURPOSE: AXI4-Full slave memory. It is the responder that the DMA read (M00) and write (M01) masters target.
// It is a byte-enabled, register-array word memory serving INCR bursts, one transaction at a time; it is used as on-chip buffer and simulation target.
// PARAMETERS
// C_S_AXI_ID_WIDTH    1     ID width; AWID/ARID are echoed on BID/RID
// C_S_AXI_DATA_WIDTH  32    data width in bits (32 or 64); ADDR_LSB = log2(DATA_WIDTH/8)
// C_S_AXI_ADDR_WIDTH  32    address width
// C_MEM_DEPTH_WORDS   1024  memory depth in words, power of 2; MEM_AW = log2(depth)
// PORTS
// S_AXI_ACLK     in   1     clock
// S_AXI_ARESETN  in   1     asynchronous active-low reset
// S_AXI_AWID     in   ID    write burst ID
// S_AXI_AWADDR   in   ADDR  write start byte address
// S_AXI_AWLEN    in   8     write beats minus 1
// S_AXI_AWVALID  in   1     write address valid
// S_AXI_AWREADY  out  1     write address accepted
// S_AXI_WDATA    in   DATA  write data
// S_AXI_WSTRB    in   DATA/8 byte enables
// S_AXI_WLAST    in   1     last write beat (informational only)
// S_AXI_WVALID   in   1     write data valid
// S_AXI_WREADY   out  1     write data accepted
// S_AXI_BID      out  ID    latched AWID
// S_AXI_BRESP    out  2     always 2'b00 (OKAY)
// S_AXI_BVALID   out  1     write response valid
// S_AXI_BREADY   in   1     write response accepted
// S_AXI_ARID     in   ID    read burst ID
// S_AXI_ARADDR   in   ADDR  read start byte address
// S_AXI_ARLEN    in   8     read beats minus 1
// S_AXI_ARVALID  in   1     read address valid
// S_AXI_ARREADY  out  1     read address accepted
// S_AXI_RID      out  ID    latched ARID
// S_AXI_RDATA    out  DATA  read data
// S_AXI_RRESP    out  2     always 2'b00 (OKAY)
// S_AXI_RLAST    out  1     last read beat
// S_AXI_RVALID   out  1     read data valid
// S_AXI_RREADY   in   1     read data accepted
// BEHAVIOUR
// - Reset (ARESETN low, async)
//   - All VALID/READY outputs, RLAST, BID, RID and RDATA go to 0; BRESP/RRESP are constant 0.
//   - FSM goes to IDLE and priority goes to write.
//   - Memory contents are NOT cleared; reset mid-burst aborts the burst and keeps beats already written.
// - FSM states: IDLE, WR, WRESP, RD.
//   - IDLE->WR on AW handshake; WR->WRESP on W handshake with beat_cnt==AWLEN.
//   - WRESP->IDLE on BVALID&&BREADY; IDLE->RD on AR handshake; RD->IDLE on R handshake with beat_cnt==ARLEN.
// - Arbitration (IDLE only)
//   - grant_w = AWVALID && (!ARVALID || prio_w); AWREADY = IDLE&&grant_w; ARREADY = IDLE&&ARVALID&&!grant_w.
//   - prio_w toggles only when both valids were high at grant time (round-robin).
// - Addressing
//   - word = Ax ADDR[ADDR_LSB +: MEM_AW]; low bits below ADDR_LSB and bits above MEM_AW are ignored.
//   - The word index increments by 1 per beat and wraps modulo depth; AxLEN 0..255 gives 1..256 beats.
//   - AxBURST/AxSIZE are not decoded; full-width INCR is the only supported mode.
// - Write: WREADY=1 throughout WR; each W handshake writes only the bytes with WSTRB[i]=1.
//   - The burst ends on beat count, not WLAST.
//   - BVALID rises the cycle after the last W handshake, carries BID=latched AWID, and holds until BREADY.
// - Read
//   - RVALID first rises 1 cycle after the AR handshake (registered read).
//   - With RREADY held high there is 1 beat per cycle; RLAST=1 only on beat ARLEN.
//   - RDATA/RLAST/RID hold stable while RVALID&&!RREADY.
// TESTING
// 1. Write 0xDEADBEEF to 0x40000010, WSTRB=4'hF, AWID=1, then read the same address with ARID=1 -> BRESP=0, BID=1, RDATA=0xDEADBEEF, RLAST=1, RID=1.
// 2. 16-beat write from address 0 with data=i, then 16-beat read with RREADY toggling each cycle -> data 0..15 in order; RLAST only on beat 16; RDATA stable while stalled.
// 3. Preload 0xAABBCCDD, write 0x11223344 with WSTRB=4'b0011 -> read returns 0xAABB3344.
// 4. Depth 1024, 4-beat write starting at word 1022 -> data lands in words 1022,1023,0,1; 4-beat read from 1022 returns it in order.
// 5. AWVALID&ARVALID together twice from IDLE -> write is served first, then read; on the next simultaneous request the read wins.
// 6. Assert ARESETN low during beat 3 of an 8-beat read -> RVALID=0 immediately; after release, a new AR is accepted and first RVALID arrives 1 cycle after the handshake.

Source files
------------

// File: rtl/dma_axi4_slave_mem.sv
// ============================================================================
// Module   : dma_axi4_slave_mem
// Brief    : AXI4 INCR-burst slave backed by a byte-enabled register-array memory
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_axi4_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_DEPTH_WORDS  = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int MEM_AW   = $clog2(C_MEM_DEPTH_WORDS);
  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    WRESP = 2'd2,
    RD    = 2'd3
  } state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic                            prio_w;
  logic [7:0]                      beat_cnt;
  logic [7:0]                      burst_len;
  logic [MEM_AW-1:0]               word_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   mem [C_MEM_DEPTH_WORDS];

  logic              grant_w;
  logic              aw_hs;
  logic              ar_hs;
  logic              w_hs;
  logic              last_beat;
  logic [MEM_AW-1:0] aw_word;
  logic [MEM_AW-1:0] ar_word;
  logic              unused_bits;

  assign grant_w   = S_AXI_AWVALID && (!S_AXI_ARVALID || prio_w);
  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign last_beat = (beat_cnt == burst_len);
  assign aw_word   = S_AXI_AWADDR[ADDR_LSB +: MEM_AW];
  assign ar_word   = S_AXI_ARADDR[ADDR_LSB +: MEM_AW];

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  // Burst length is tracked by beat count, so WLAST and the out-of-range address bits are ignored
  assign unused_bits = ^{S_AXI_WLAST, S_AXI_AWADDR, S_AXI_ARADDR};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_w) begin
          S_AXI_AWREADY = 1'b1;
          state_nxt     = WR;
        end else if (S_AXI_ARVALID) begin
          S_AXI_ARREADY = 1'b1;
          state_nxt     = RD;
        end
      end
      WR: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        if (S_AXI_BVALID && S_AXI_BREADY) state_nxt = IDLE;
      end
      RD: begin
        if (S_AXI_RVALID && S_AXI_RREADY && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      prio_w       <= 1'b1;
      beat_cnt     <= 8'd0;
      burst_len    <= 8'd0;
      word_addr    <= '0;
      S_AXI_BID    <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_RID    <= '0;
      S_AXI_RDATA  <= '0;
      S_AXI_RLAST  <= 1'b0;
      S_AXI_RVALID <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Round-robin only flips when both channels actually competed
          if (S_AXI_AWVALID && S_AXI_ARVALID) prio_w <= !prio_w;
          if (aw_hs) begin
            S_AXI_BID <= S_AXI_AWID;
            burst_len <= S_AXI_AWLEN;
            word_addr <= aw_word;
            beat_cnt  <= 8'd0;
          end else if (ar_hs) begin
            S_AXI_RID    <= S_AXI_ARID;
            burst_len    <= S_AXI_ARLEN;
            word_addr    <= ar_word + 1'b1;
            beat_cnt     <= 8'd0;
            S_AXI_RDATA  <= mem[ar_word];
            S_AXI_RLAST  <= (S_AXI_ARLEN == 8'd0);
            S_AXI_RVALID <= 1'b1;
          end
        end
        WR: begin
          if (w_hs) begin
            word_addr <= word_addr + 1'b1;
            beat_cnt  <= beat_cnt + 8'd1;
            if (last_beat) S_AXI_BVALID <= 1'b1;
          end
        end
        WRESP: begin
          if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
        end
        RD: begin
          // word_addr runs one word ahead so the next beat is fetched on each accept
          if (S_AXI_RREADY) begin
            if (last_beat) begin
              S_AXI_RVALID <= 1'b0;
              S_AXI_RLAST  <= 1'b0;
            end else begin
              S_AXI_RDATA <= mem[word_addr];
              word_addr   <= word_addr + 1'b1;
              beat_cnt    <= beat_cnt + 8'd1;
              S_AXI_RLAST <= (beat_cnt + 8'd1 == burst_len);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_hs) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (S_AXI_WSTRB[i]) mem[word_addr][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire
